// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared state encoding and sizing constants for the FIFO
//               write-side round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int IDX_W_DEF      = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector: first eligible index
//               after 'last', wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        valid      = 1'b0;
        index      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_cand     = (int'(last) + off) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (eligible[w_cand_idx]) begin
                valid = 1'b1;
                index = w_cand_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter merging NUM_REQ write requesters into one
//               FIFO write port, with full-flag stall and overflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    input  logic                          overflow,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          wen,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          stall,
    output logic [7:0]                    ovf_cnt
);

    localparam int               c_idx_w    = idx_width(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(NUM_REQ - 1);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [c_idx_w-1:0]      r_last;
    logic [NUM_REQ-1:0]      r_grant;
    logic                    r_wen;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [7:0]              r_ovf_cnt;

    logic [NUM_REQ-1:0]      w_eligible;
    logic                    w_pick_valid;
    logic [c_idx_w-1:0]      w_pick_idx;
    logic                    w_issue;
    logic [NUM_REQ-1:0]      w_onehot;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    // A requester granted this cycle is still showing the data just consumed.
    assign w_eligible = req & ~r_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .eligible (w_eligible),
        .last     (r_last),
        .valid    (w_pick_valid),
        .index    (w_pick_idx)
    );

    always_comb begin
        w_onehot   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == c_idx_w'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // All states share one edge rule; the state only remembers a full-blocked wait.
    always_comb begin
        w_next_state = ST_IDLE;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ARB, ST_STALL: begin
                if (!en || !w_pick_valid) begin
                    w_next_state = ST_IDLE;
                end else if (full) begin
                    w_next_state = ST_STALL;
                end else begin
                    w_next_state = ST_ARB;
                    w_issue      = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state   <= ST_IDLE;
            r_last    <= c_last_rst;
            r_grant   <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_ovf_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_wen   <= w_issue;
            r_grant <= w_issue ? w_onehot : '0;
            if (w_issue) begin
                r_wdata <= w_sel_data;
                r_last  <= w_pick_idx;
            end
            if (overflow && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    assign grant   = r_grant;
    assign wen     = r_wen;
    assign wdata   = r_wdata;
    assign stall   = (r_state == ST_STALL);
    assign ovf_cnt = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            wclk = 1'b0;
    logic            wrst;
    logic            en;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            full;
    logic            overflow;
    logic [N-1:0]    grant;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic            stall;
    logic [7:0]      ovf_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [N-1:0]  m_grant;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic          m_stall;
    int            m_last;
    int            m_cnt;

    typedef struct {
        logic         en;
        logic [N-1:0] req;
        logic         full;
        logic         ovf;
        logic [N-1:0] g;
        logic         w;
        logic [DW-1:0] d;
        logic         s;
        logic [7:0]   c;
    } vec_t;

    vec_t tbl [18];

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .overflow (overflow),
        .grant    (grant),
        .wen      (wen),
        .wdata    (wdata),
        .stall    (stall),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant = '0;
        m_wen   = 1'b0;
        m_wdata = '0;
        m_stall = 1'b0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    // One clock edge of the arbiter as described by its rules, using the
    // inputs currently applied.
    task automatic model_edge();
        int elig;
        int k;
        elig = int'(req) & ~int'(m_grant);
        k = -1;
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (m_last + off) % N;
            if (k < 0 && ((elig >> c) & 1) == 1) k = c;
        end
        m_grant = '0;
        m_wen   = 1'b0;
        m_stall = 1'b0;
        if (en && k >= 0) begin
            if (full) begin
                m_stall = 1'b1;
            end else begin
                m_grant = N'(1 << k);
                m_wen   = 1'b1;
                m_wdata = DW'(req_data >> (k * DW));
                m_last  = k;
            end
        end
        if (overflow && m_cnt < 255) m_cnt++;
    endtask

    task automatic model_check();
        check("grant",   64'(grant),   64'(m_grant));
        check("wen",     64'(wen),     64'(m_wen));
        check("wdata",   64'(wdata),   64'(m_wdata));
        check("stall",   64'(stall),   64'(m_stall));
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
    endtask

    task automatic tick();
        model_edge();
        @(posedge wclk);
        #1;
        model_check();
    endtask

    // Reset is raised mid-cycle so the outputs are checked before any edge.
    task automatic do_reset();
        wrst = 1'b1;
        #2;
        check("rst_grant",   64'(grant),   64'(0));
        check("rst_wen",     64'(wen),     64'(0));
        check("rst_wdata",   64'(wdata),   64'(0));
        check("rst_stall",   64'(stall),   64'(0));
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        model_reset();
    endtask

    initial begin
        wrst     = 1'b0;
        en       = 1'b0;
        req      = '0;
        req_data = '0;
        full     = 1'b0;
        overflow = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Directed table from reset: rotation, enable gating, stall, single requester
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h11, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h22, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h33, 1'b0, 8'd1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 8'h44, 1'b0, 8'd2};
        tbl[4]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h11, 1'b0, 8'd2};
        tbl[5]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h11, 1'b0, 8'd2};
        tbl[6]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h11, 1'b0, 8'd2};
        tbl[7]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h22, 1'b0, 8'd2};
        tbl[8]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h22, 1'b1, 8'd2};
        tbl[9]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h22, 1'b1, 8'd2};
        tbl[10] = '{1'b1, 4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h44, 1'b0, 8'd2};
        tbl[11] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b0, 8'd2};
        tbl[12] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b0, 8'd2};
        tbl[13] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b0, 8'd2};
        tbl[14] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b0, 8'd2};
        tbl[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b0, 8'd2};
        tbl[16] = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b1, 8'd2};
        tbl[17] = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b0, 8'd2};

        req_data = 32'h44332211;
        for (int i = 0; i < 18; i++) begin
            en       = tbl[i].en;
            req      = tbl[i].req;
            full     = tbl[i].full;
            overflow = tbl[i].ovf;
            tick();
            check($sformatf("vec%0d", i),
                  64'({grant, wen, wdata, stall, ovf_cnt}),
                  64'({tbl[i].g, tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].c}));
        end

        // Held off by full for five edges, then requester 0 goes first
        overflow = 1'b0;
        do_reset();
        en   = 1'b1;
        req  = 4'b0011;
        full = 1'b1;
        repeat (5) begin
            tick();
            check("full_hold_wen",   64'(wen),   64'(0));
            check("full_hold_stall", 64'(stall), 64'(1));
        end
        full = 1'b0;
        tick();
        check("full_release_grant", 64'(grant), 64'(4'b0001));
        check("full_release_stall", 64'(stall), 64'(0));

        // Overflow counter saturation, then cleared by reset
        do_reset();
        en       = 1'b0;
        req      = '0;
        overflow = 1'b1;
        repeat (300) tick();
        check("ovf_saturated", 64'(ovf_cnt), 64'(255));
        overflow = 1'b0;
        do_reset();

        // Reset while a write is on the port
        en       = 1'b1;
        req      = 4'b1111;
        req_data = 32'hA4B3C2D1;
        tick();
        check("midwrite_wen", 64'(wen), 64'(1));
        do_reset();
        req = '0;
        tick();
        check("post_rst_no_grant", 64'(grant), 64'(0));
        req = 4'b0001;
        tick();
        check("post_rst_first_grant", 64'(grant), 64'(4'b0001));
        check("post_rst_wdata", 64'(wdata), 64'(8'hD1));

        // Randomized traffic with occasional resets
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end
            en       = ($urandom_range(0, 9) != 0);
            full     = ($urandom_range(0, 3) == 0);
            overflow = ($urandom_range(0, 4) == 0);
            req      = N'($urandom);
            req_data = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
